// File: rtl/sync_framer.sv
// Transmit framer: prepends the sync marker to each RS codeword and packs the
// byte stream MSB-first into 32-bit words, continuously across frame boundaries.
module sync_framer #(
  parameter logic [31:0] SYNC_MARKER  = 32'h1ACFFC1D,
  parameter int unsigned CODEWORD_LEN = 255,
  parameter logic [7:0]  PAD_BYTE     = 8'h00
) (
  input  logic        core_clk,
  input  logic        rst_n,
  input  logic [7:0]  s_axis_input_tdata,
  input  logic        s_axis_input_tvalid,
  input  logic        s_axis_input_tlast,
  output logic        s_axis_input_tready,
  output logic [31:0] m_axis_output_tdata,
  output logic        m_axis_output_tvalid,
  input  logic        m_axis_output_tready,
  input  logic        flush_i,
  output logic        tlast_err_o,
  output logic [15:0] frame_cnt_o
);

  typedef enum logic [1:0] {S_IDLE, S_MARK, S_DATA} state_t;

  localparam logic [7:0] LAST_CNT = 8'(CODEWORD_LEN);

  state_t      state;
  logic [1:0]  mark_idx;
  logic [1:0]  fill_cnt;
  logic [7:0]  byte_cnt;
  logic [31:0] word_reg;
  logic        pad_busy;

  logic        pk_ok;
  logic        s_hs;
  logic        wr_en;
  logic [7:0]  wr_byte;
  logic [7:0]  mark_byte;

  assign pk_ok = (fill_cnt != 2'd3) || !m_axis_output_tvalid || m_axis_output_tready;
  assign s_axis_input_tready = (state == S_DATA) && pk_ok;
  assign s_hs = s_axis_input_tvalid && s_axis_input_tready;

  always_comb begin
    unique case (mark_idx)
      2'd0:    mark_byte = SYNC_MARKER[31:24];
      2'd1:    mark_byte = SYNC_MARKER[23:16];
      2'd2:    mark_byte = SYNC_MARKER[15:8];
      default: mark_byte = SYNC_MARKER[7:0];
    endcase
  end

  // A started pad always completes its word; otherwise a waiting frame beats flush.
  always_comb begin
    wr_en   = 1'b0;
    wr_byte = PAD_BYTE;
    unique case (state)
      S_IDLE: wr_en = pk_ok && (pad_busy ||
                      (flush_i && (fill_cnt != 2'd0) && !s_axis_input_tvalid));
      S_MARK: begin
        wr_en   = pk_ok;
        wr_byte = mark_byte;
      end
      S_DATA: begin
        wr_en   = s_hs;
        wr_byte = s_axis_input_tdata;
      end
      default: wr_en = 1'b0;
    endcase
  end

  always_ff @(posedge core_clk or negedge rst_n) begin
    if (!rst_n) begin
      state                <= S_IDLE;
      mark_idx             <= '0;
      fill_cnt             <= '0;
      byte_cnt             <= '0;
      word_reg             <= '0;
      pad_busy             <= 1'b0;
      m_axis_output_tdata  <= '0;
      m_axis_output_tvalid <= 1'b0;
      tlast_err_o          <= 1'b0;
      frame_cnt_o          <= '0;
    end else begin
      if (wr_en && (fill_cnt == 2'd3)) begin
        m_axis_output_tdata  <= {word_reg[31:8], wr_byte};
        m_axis_output_tvalid <= 1'b1;
        fill_cnt             <= '0;
      end else begin
        if (m_axis_output_tready)
          m_axis_output_tvalid <= 1'b0;
        if (wr_en) begin
          unique case (fill_cnt)
            2'd0:    word_reg[31:24] <= wr_byte;
            2'd1:    word_reg[23:16] <= wr_byte;
            default: word_reg[15:8]  <= wr_byte;
          endcase
          fill_cnt <= fill_cnt + 2'd1;
        end
      end

      tlast_err_o <= s_hs && (s_axis_input_tlast != (byte_cnt == LAST_CNT));

      unique case (state)
        S_IDLE: begin
          if (wr_en)
            pad_busy <= (fill_cnt != 2'd3);
          if (s_axis_input_tvalid && !pad_busy) begin
            state    <= S_MARK;
            mark_idx <= '0;
          end
        end
        S_MARK: begin
          if (pk_ok) begin
            mark_idx <= mark_idx + 2'd1;
            if (mark_idx == 2'd3) begin
              state    <= S_DATA;
              byte_cnt <= 8'd1;
            end
          end
        end
        S_DATA: begin
          if (s_hs) begin
            if (byte_cnt == LAST_CNT) begin
              state       <= S_IDLE;
              byte_cnt    <= '0;
              frame_cnt_o <= frame_cnt_o + 16'd1;
            end else begin
              byte_cnt <= byte_cnt + 8'd1;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
